// File: rtl/mul_ctrl_if.sv
// Signal bundle between the execute stage / external multiplier and mul_ctrl.
// The master side (pipeline plus combinational multiplier) drives requests and the product.
interface mul_ctrl_if;
  logic        req_i;
  logic [2:0]  funct3_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic [31:0] mul_data1_o;
  logic [31:0] mul_data2_o;
  logic [2:0]  mul_op_code_o;
  logic [63:0] mul_res_i;
  logic        stall_o;
  logic        res_valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  modport master (
    output req_i, funct3_i, data1_i, data2_i, rd_addr_i, flush_i, mul_res_i,
    input  mul_data1_o, mul_data2_o, mul_op_code_o, stall_o, res_valid_o, result_o, rd_addr_o
  );

  modport slave (
    input  req_i, funct3_i, data1_i, data2_i, rd_addr_i, flush_i, mul_res_i,
    output mul_data1_o, mul_data2_o, mul_op_code_o, stall_o, res_valid_o, result_o, rd_addr_o
  );
endinterface

// File: rtl/mul_ctrl.sv
// RV32M multiply sequencer: captures operands, drives an external combinational
// multiplier for one cycle and reuses the last product through a one-entry cache.
`ifndef MUL
`define MUL 3'd0
`endif
`ifndef MULSU
`define MULSU 3'd1
`endif
`ifndef MULU
`define MULU 3'd2
`endif

module mul_ctrl (
  input  logic      clk,
  input  logic      rst,
  mul_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [31:0] op1_reg, op2_reg, cache_op1_reg, cache_op2_reg, result_reg;
  logic [2:0]  code_reg, cache_code_reg, req_code;
  logic [4:0]  rd_reg, rd_out_reg;
  logic [63:0] product_reg;
  logic        hi_reg, req_hi, cache_valid_reg, accept, cache_hit;
  logic        stall_next, res_valid_next;

  function automatic logic [31:0] pick(input logic [63:0] p, input logic hi);
    return hi ? p[63:32] : p[31:0];
  endfunction

  always_comb begin
    case (bus.funct3_i)
      3'b010:  req_code = `MULSU;
      3'b011:  req_code = `MULU;
      default: req_code = `MUL;
    endcase
  end

  assign req_hi = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b010) || (bus.funct3_i == 3'b011);
  assign accept = (state_reg == IDLE) && bus.req_i && !bus.flush_i;
  // product_reg doubles as the cached product: it only ever holds the last completed result
  assign cache_hit = cache_valid_reg && (bus.data1_i == cache_op1_reg) &&
                     (bus.data2_i == cache_op2_reg) && (req_code == cache_code_reg);

  always_comb begin
    state_next     = state_reg;
    stall_next     = 1'b0;
    res_valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = cache_hit ? DONE : CALC;
          stall_next = 1'b1;
        end
      end
      CALC: begin
        state_next = DONE;
        stall_next = 1'b1;
      end
      DONE: begin
        state_next     = IDLE;
        res_valid_next = !bus.flush_i;
      end
      default: state_next = IDLE;
    endcase
    if (bus.flush_i) state_next = IDLE;
    if (rst) stall_next = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      op1_reg         <= '0;
      op2_reg         <= '0;
      code_reg        <= '0;
      hi_reg          <= 1'b0;
      rd_reg          <= '0;
      product_reg     <= '0;
      cache_valid_reg <= 1'b0;
      cache_op1_reg   <= '0;
      cache_op2_reg   <= '0;
      cache_code_reg  <= '0;
      result_reg      <= '0;
      rd_out_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op1_reg  <= bus.data1_i;
        op2_reg  <= bus.data2_i;
        code_reg <= req_code;
        hi_reg   <= req_hi;
        rd_reg   <= bus.rd_addr_i;
        if (cache_hit) begin
          result_reg <= pick(product_reg, req_hi);
          rd_out_reg <= bus.rd_addr_i;
        end
      end
      if ((state_reg == CALC) && !bus.flush_i) begin
        product_reg     <= bus.mul_res_i;
        result_reg      <= pick(bus.mul_res_i, hi_reg);
        rd_out_reg      <= rd_reg;
        cache_valid_reg <= 1'b1;
        cache_op1_reg   <= op1_reg;
        cache_op2_reg   <= op2_reg;
        cache_code_reg  <= code_reg;
      end
    end
  end

  assign bus.mul_data1_o   = op1_reg;
  assign bus.mul_data2_o   = op2_reg;
  assign bus.mul_op_code_o = code_reg;
  assign bus.stall_o       = stall_next;
  assign bus.res_valid_o   = res_valid_next;
  assign bus.result_o      = result_reg;
  assign bus.rd_addr_o     = rd_out_reg;
endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl: an arithmetic model predicts each result and
// its hit/miss latency; a per-cycle monitor checks pulses and held outputs.
module tb_mul_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_ctrl_if bus();
  mul_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [2:0] C_MUL = 3'd0, C_MULSU = 3'd1, C_MULU = 3'd2;
  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  function automatic logic [63:0] ext(input logic [31:0] v, input logic sgn);
    return sgn ? {{32{v[31]}}, v} : {32'h0, v};
  endfunction

  // external combinational multiplier seen by the DUT
  assign bus.mul_res_i = ext(bus.mul_data1_o, bus.mul_op_code_o != C_MULU) *
                         ext(bus.mul_data2_o, bus.mul_op_code_o == C_MUL);

  function automatic logic [31:0] model_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (f3)
      F_MULH:   begin p = ext(a, 1'b1) * ext(b, 1'b1); return p[63:32]; end
      F_MULHSU: begin p = ext(a, 1'b1) * ext(b, 1'b0); return p[63:32]; end
      F_MULHU:  begin p = ext(a, 1'b0) * ext(b, 1'b0); return p[63:32]; end
      default:  begin p = ext(a, 1'b1) * ext(b, 1'b1); return p[31:0]; end
    endcase
  endfunction

  function automatic logic [2:0] model_class(input logic [2:0] f3);
    return (f3 == F_MULHU) ? C_MULU : (f3 == F_MULHSU) ? C_MULSU : C_MUL;
  endfunction

  logic        m_cache_v;
  logic [31:0] m_cache_a, m_cache_b;
  logic [2:0]  m_cache_cls;

  logic [31:0] exp_res_q[$];
  logic [4:0]  exp_rd_q[$];
  logic [31:0] last_res;
  logic [4:0]  last_rd;
  logic [31:0] got_res;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_res = '0;
      last_rd  = '0;
    end else if (bus.res_valid_o) begin
      pulses++;
      if (exp_res_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: res_valid_o=1 required=0 result_o=0x%0h", bus.result_o);
      end else begin
        logic [31:0] er;
        logic [4:0]  ed;
        er = exp_res_q.pop_front();
        ed = exp_rd_q.pop_front();
        check("result", 64'(bus.result_o), 64'(er));
        check("rd_addr", 64'(bus.rd_addr_o), 64'(ed));
        $display("txn: result=0x%08h rd=%0d", bus.result_o, bus.rd_addr_o);
      end
      last_res = bus.result_o;
      last_rd  = bus.rd_addr_o;
    end else begin
      check("result_hold", 64'(bus.result_o), 64'(last_res));
      check("rd_hold", 64'(bus.rd_addr_o), 64'(last_rd));
    end
  end

  // called just after a rising edge; leaves req_i high, returns just after the edge ending DONE
  task automatic do_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    logic hit;
    int   lat;
    hit = m_cache_v && (a == m_cache_a) && (b == m_cache_b) && (model_class(f3) == m_cache_cls);
    bus.req_i = 1'b1; bus.flush_i = 1'b0;
    bus.funct3_i = f3; bus.data1_i = a; bus.data2_i = b; bus.rd_addr_i = rd;
    exp_res_q.push_back(model_result(f3, a, b));
    exp_rd_q.push_back(rd);
    @(negedge clk);
    check("stall_accept", 64'(bus.stall_o), 64'(1));
    @(posedge clk); #1;
    lat = 0;
    while (lat < 4) begin
      @(negedge clk);
      lat++;
      if (bus.res_valid_o) break;
      check("stall_calc", 64'(bus.stall_o), 64'(1));
      check("mul_data1", 64'(bus.mul_data1_o), 64'(a));
      check("mul_data2", 64'(bus.mul_data2_o), 64'(b));
      check("mul_op_code", 64'(bus.mul_op_code_o), 64'(model_class(f3)));
    end
    check("latency", 64'(lat), hit ? 64'(1) : 64'(2));
    check("stall_done", 64'(bus.stall_o), 64'(0));
    got_res = bus.result_o;
    if (!hit) begin
      m_cache_v = 1'b1; m_cache_a = a; m_cache_b = b; m_cache_cls = model_class(f3);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.req_i = 1'b0;
    bus.flush_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    m_cache_v = 1'b0; m_cache_a = '0; m_cache_b = '0; m_cache_cls = '0;
    got_res = '0;
    rst = 1'b1;
    bus.req_i = 1'b1; bus.flush_i = 1'b0; bus.funct3_i = F_MULHU;
    bus.data1_i = 32'hDEAD_BEEF; bus.data2_i = 32'h1234_5678; bus.rd_addr_i = 5'd31;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 64'(bus.stall_o), 64'(0));
    check("rst_valid", 64'(bus.res_valid_o), 64'(0));
    check("rst_result", 64'(bus.result_o), 64'(0));
    check("rst_rd", 64'(bus.rd_addr_o), 64'(0));
    check("rst_mul_data1", 64'(bus.mul_data1_o), 64'(0));
    check("rst_mul_data2", 64'(bus.mul_data2_o), 64'(0));
    check("rst_op_code", 64'(bus.mul_op_code_o), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // signed MUL, then MULH miss followed by MUL hit on the same operands
    do_req(F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
    check("lit_mul_7x-3", 64'(got_res), 64'hFFFF_FFEB);
    idle(1);
    do_req(F_MULH, 32'h8000_0000, 32'h8000_0000, 5'd6);
    check("lit_mulh_min", 64'(got_res), 64'h4000_0000);
    do_req(F_MUL, 32'h8000_0000, 32'h8000_0000, 5'd7);
    check("lit_mul_min_hit", 64'(got_res), 64'h0);
    idle(1);
    do_req(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
    check("lit_mulhu", 64'(got_res), 64'hFFFF_FFFE);
    do_req(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    check("lit_mulhsu", 64'(got_res), 64'hFFFF_FFFF);
    idle(1);

    // flush while in CALC: op is dropped and the cache is not updated
    bus.req_i = 1'b1; bus.funct3_i = F_MUL; bus.data1_i = 32'd1000; bus.data2_i = 32'd1000; bus.rd_addr_i = 5'd3;
    @(posedge clk); #1;
    bus.req_i = 1'b0; bus.flush_i = 1'b1;
    @(negedge clk);
    check("flush_calc_valid", 64'(bus.res_valid_o), 64'(0));
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_idle_stall", 64'(bus.stall_o), 64'(0));
    idle(2);
    do_req(F_MUL, 32'd1000, 32'd1000, 5'd3);
    check("lit_after_flush", 64'(got_res), 64'h000F_4240);
    idle(1);

    // flush together with a request in IDLE: nothing is captured
    bus.req_i = 1'b1; bus.flush_i = 1'b1; bus.funct3_i = F_MULHU; bus.data1_i = 32'd9; bus.data2_i = 32'd9; bus.rd_addr_i = 5'd7;
    @(negedge clk);
    check("flush_req_stall", 64'(bus.stall_o), 64'(0));
    @(posedge clk); #1;
    bus.req_i = 1'b0; bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_req_nocapture", 64'(bus.mul_data1_o), 64'(1000));
    check("flush_req_stall_after", 64'(bus.stall_o), 64'(0));
    idle(2);

    // reset while in CALC
    bus.req_i = 1'b1; bus.funct3_i = F_MULHU; bus.data1_i = 32'd1000; bus.data2_i = 32'd1000; bus.rd_addr_i = 5'd4;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    rst = 1'b1;
    #1;
    check("rstcalc_stall", 64'(bus.stall_o), 64'(0));
    check("rstcalc_valid", 64'(bus.res_valid_o), 64'(0));
    check("rstcalc_result", 64'(bus.result_o), 64'(0));
    check("rstcalc_rd", 64'(bus.rd_addr_o), 64'(0));
    check("rstcalc_mul_data1", 64'(bus.mul_data1_o), 64'(0));
    m_cache_v = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
    do_req(F_MUL, 32'd1000, 32'd1000, 5'd4);
    check("lit_first_after_rst", 64'(got_res), 64'h000F_4240);

    // back-to-back with req_i held high
    idle(1);
    p0 = pulses;
    do_req(F_MUL, 32'd5, 32'd6, 5'd8);
    check("lit_b2b_mul", 64'(got_res), 64'd30);
    do_req(F_MULH, 32'd5, 32'd6, 5'd9);
    check("lit_b2b_mulh_hit", 64'(got_res), 64'd0);
    do_req(3'b100, 32'd5, 32'd6, 5'd10);
    check("lit_b2b_f3_100", 64'(got_res), 64'd30);
    do_req(F_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11);
    do_req(F_MULHSU, 32'hFFFF_FFFE, 32'd3, 5'd12);
    check("lit_b2b_mulhsu", 64'(got_res), 64'hFFFF_FFFF);
    idle(3);
    check("b2b_pulse_count", 64'(pulses - p0), 64'(5));
    check("queue_drained", 64'(exp_res_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
